timer_share_ctrl: RTL and testbench

- Shares a single serial-programmed fancy-timer instance among NREQ requesters using round-robin arbitration.
- For each granted request, the block serializes the start pattern 1101 and the requester's 4-bit delay onto the timer's data line.
- It then waits for the timer's done, acknowledges it, and returns a one-cycle completion pulse to the winning requester.
- A watchdog recovers the shared timer if done never arrives.

---
 rtl/timer_share_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_timer_share_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_share_ctrl.sv
// Round-robin sharing of one serial-programmed timer among NREQ requesters:
// frames 1101+delay to the timer, waits for done (with watchdog), then strobes the winner.
module timer_share_ctrl #(
  parameter int NREQ        = 4,
  parameter int WDOG_CYCLES = 16100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_delay,
  output logic [NREQ-1:0]   done_pulse,
  output logic              timeout,
  output logic              busy,
  output logic [NREQ-1:0]   grant,
  output logic              tmr_data,
  output logic              tmr_ack,
  output logic              tmr_rst,
  input  logic              tmr_done,
  input  logic              tmr_counting
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, ACK, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_pulse_q, done_pulse_d;
  logic            timeout_q, timeout_d;
  logic            tmr_data_q, tmr_data_d;
  logic            tmr_ack_q, tmr_ack_d;
  logic            tmr_rst_q, tmr_rst_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   idx_q, idx_d;
  logic [7:0]      frame_q, frame_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            seen_q, seen_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cand;
  logic            to_ack;
  logic            to_flag;
  logic [7:0]      new_frame;

  // First pending request at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    done_pulse_d = '0;
    timeout_d    = 1'b0;
    tmr_data_d   = 1'b0;
    tmr_ack_d    = 1'b0;
    tmr_rst_d    = 1'b0;
    idx_d        = idx_q;
    frame_d      = frame_q;
    bitcnt_d     = bitcnt_q;
    wdog_d       = wdog_q;
    seen_d       = seen_q;
    to_ack       = 1'b0;
    to_flag      = 1'b0;
    new_frame    = {4'b1101, req_delay[4*pick +: 4]};

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = SEND;
          idx_d      = pick;
          grant_d    = ONE << pick;
          frame_d    = new_frame;
          bitcnt_d   = 3'd0;
          tmr_data_d = new_frame[7];
        end
      end
      SEND: begin
        // tmr_data is registered one step ahead so it lines up with bitcnt_q.
        if (bitcnt_q == 3'd7) begin
          state_d = WAIT;
          wdog_d  = '0;
          seen_d  = 1'b0;
        end else begin
          bitcnt_d   = bitcnt_q + 3'd1;
          tmr_data_d = frame_q[3'd6 - bitcnt_q];
        end
      end
      WAIT: begin
        if (wdog_q != {WW{1'b1}}) wdog_d = wdog_q + 1'b1;
        seen_d = seen_q | tmr_counting;
        // done already high on entry, or counting never started: lost frame.
        if (wdog_q == '0 && tmr_done) begin
          to_ack  = 1'b1;
          to_flag = 1'b1;
        end else if (wdog_q == WW'(1) && !seen_q && !tmr_counting) begin
          to_ack  = 1'b1;
          to_flag = 1'b1;
        end else if (tmr_done) begin
          to_ack  = 1'b1;
        end else if (wdog_q >= WW'(WDOG_CYCLES - 1)) begin
          to_ack  = 1'b1;
          to_flag = 1'b1;
        end
        if (to_ack) begin
          state_d      = ACK;
          done_pulse_d = grant_q;
          timeout_d    = to_flag;
          tmr_ack_d    = !to_flag;
          tmr_rst_d    = to_flag;
        end
      end
      ACK: begin
        state_d  = GAP;
        rr_ptr_d = PW'((int'(idx_q) + 1) % NREQ);
        grant_d  = '0;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      done_pulse_q <= '0;
      timeout_q    <= 1'b0;
      tmr_data_q   <= 1'b0;
      tmr_ack_q    <= 1'b0;
      tmr_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      done_pulse_q <= done_pulse_d;
      timeout_q    <= timeout_d;
      tmr_data_q   <= tmr_data_d;
      tmr_ack_q    <= tmr_ack_d;
      tmr_rst_q    <= tmr_rst_d;
      busy_q       <= busy_d;
    end
  end

  // Job context is only meaningful while the FSM is out of IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    idx_q    <= idx_d;
    frame_q  <= frame_d;
    bitcnt_q <= bitcnt_d;
    wdog_q   <= wdog_d;
    seen_q   <= seen_d;
  end

  assign done_pulse = done_pulse_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;
  assign grant      = grant_q;
  assign tmr_data   = tmr_data_q;
  assign tmr_ack    = tmr_ack_q;
  assign tmr_rst    = tmr_rst_q;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// Bench for timer_share_ctrl: a behavioural serial timer, a table of arbitration
// vectors, random request traffic against a round-robin model, and corner sequences.
module tb_timer_share_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main instance (default watchdog) driven by the timer model
  logic [3:0]  req_m = '0;
  logic [15:0] dly_m = '0;
  logic [3:0]  done_m, grant_m;
  logic        to_m, busy_m, td_m, ack_m, rst_m;
  logic        tdone_m, tcnt_m;

  // Short-watchdog instance with timer inputs forced by the bench
  logic [3:0]  req_w = '0;
  logic [15:0] dly_w = '0;
  logic [3:0]  done_w, grant_w;
  logic        to_w, busy_w, td_w, ack_w, rst_w;
  logic        tdone_w = 1'b0;
  logic        tcnt_w  = 1'b1;

  timer_share_ctrl #(.NREQ(4), .WDOG_CYCLES(16100)) dut (
    .clk(clk), .reset(reset), .req(req_m), .req_delay(dly_m),
    .done_pulse(done_m), .timeout(to_m), .busy(busy_m), .grant(grant_m),
    .tmr_data(td_m), .tmr_ack(ack_m), .tmr_rst(rst_m),
    .tmr_done(tdone_m), .tmr_counting(tcnt_m)
  );

  timer_share_ctrl #(.NREQ(4), .WDOG_CYCLES(100)) dut_wd (
    .clk(clk), .reset(reset), .req(req_w), .req_delay(dly_w),
    .done_pulse(done_w), .timeout(to_w), .busy(busy_w), .grant(grant_w),
    .tmr_data(td_w), .tmr_ack(ack_w), .tmr_rst(rst_w),
    .tmr_done(tdone_w), .tmr_counting(tcnt_w)
  );

  // Timer: hunt for 1101, take 4 delay bits, count (d+1)*1000, hold done until ack.
  int         tm_mode = 0;
  logic [3:0] tm_sh = '0;
  logic [3:0] tm_d = '0;
  int         tm_nb = 0;
  int         tm_cnt = 0;
  int         tm_len = 0;
  initial begin
    tdone_m = 1'b0;
    tcnt_m  = 1'b0;
  end
  always @(posedge clk) begin
    if (reset || rst_m) begin
      tm_mode <= 0; tm_sh <= '0; tm_nb <= 0; tdone_m <= 1'b0; tcnt_m <= 1'b0;
    end else begin
      case (tm_mode)
        0: begin
          tm_sh <= {tm_sh[2:0], td_m};
          if ({tm_sh[2:0], td_m} == 4'b1101) begin tm_mode <= 1; tm_nb <= 0; end
        end
        1: begin
          tm_d  <= {tm_d[2:0], td_m};
          tm_nb <= tm_nb + 1;
          if (tm_nb == 3) begin
            tm_mode <= 2; tm_cnt <= 0; tcnt_m <= 1'b1;
            tm_len  <= (int'({tm_d[2:0], td_m}) + 1) * 1000;
          end
        end
        2: begin
          if (tm_cnt == tm_len - 1) begin tm_mode <= 3; tcnt_m <= 1'b0; tdone_m <= 1'b1; end
          else tm_cnt <= tm_cnt + 1;
        end
        default: if (ack_m) begin tm_mode <= 0; tm_sh <= '0; tdone_m <= 1'b0; end
      endcase
    end
  end

  logic       use_wd = 1'b0;
  logic [3:0] s_grant, s_done;
  logic       s_to, s_busy, s_tdata, s_ack, s_rst;
  assign s_grant = use_wd ? grant_w : grant_m;
  assign s_done  = use_wd ? done_w  : done_m;
  assign s_to    = use_wd ? to_w    : to_m;
  assign s_busy  = use_wd ? busy_w  : busy_m;
  assign s_tdata = use_wd ? td_w    : td_m;
  assign s_ack   = use_wd ? ack_w   : ack_m;
  assign s_rst   = use_wd ? rst_w   : rst_m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic raise(input int i, input logic [3:0] d);
    if (use_wd) begin
      if (!req_w[i]) begin req_w[i] = 1'b1; dly_w[4*i +: 4] = d; end
    end else begin
      if (!req_m[i]) begin req_m[i] = 1'b1; dly_m[4*i +: 4] = d; end
    end
  endtask

  task automatic drop(input int i);
    if (use_wd) req_w[i] = 1'b0;
    else        req_m[i] = 1'b0;
  endtask

  function automatic logic [3:0] cur_d(input int i);
    return use_wd ? dly_w[4*i +: 4] : dly_m[4*i +: 4];
  endfunction

  // One complete job from grant to the IDLE cycle after GAP; called at a negedge.
  task automatic run_job(input int idx, input int wait_len, input bit exp_to, input bit early);
    logic [7:0] fr;
    bit got;
    bit ack_seen;
    int cnt;
    fr  = {4'b1101, cur_d(idx)};
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_grant != 0) begin got = 1'b1; break; end
    end
    if (!got) begin chk("grant_wait", 0, 1); return; end
    chk("grant", int'(s_grant), 1 << idx);
    chk("busy_send", int'(s_busy), 1);
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      chk($sformatf("frame_bit%0d", b), int'(s_tdata), int'(fr[7-b]));
    end
    @(negedge clk);
    chk("wait_data", int'(s_tdata), 0);
    cnt = 0; got = 1'b0; ack_seen = 1'b0;
    for (int n = 0; n < wait_len + 20; n++) begin
      if (early && cnt == 5) drop(idx);
      if (s_done != 0) begin got = 1'b1; break; end
      if (s_ack || s_rst) ack_seen = 1'b1;
      @(negedge clk);
      cnt++;
    end
    if (!got) begin chk("done_wait", 0, 1); return; end
    chk("wait_len", cnt, wait_len);
    chk("done_pulse", int'(s_done), 1 << idx);
    chk("timeout", int'(s_to), int'(exp_to));
    chk("ack_pulse", int'(s_ack), int'(!exp_to));
    chk("rst_pulse", int'(s_rst), int'(exp_to));
    chk("early_ack_or_rst", int'(ack_seen), 0);
    chk("busy_ack", int'(s_busy), 1);
    drop(idx);
    @(negedge clk);
    chk("gap_grant", int'(s_grant), 0);
    chk("gap_ack", int'(s_ack), 0);
    chk("gap_rst", int'(s_rst), 0);
    chk("gap_done", int'(s_done), 0);
    chk("gap_busy", int'(s_busy), 1);
    @(negedge clk);
    chk("idle_busy", int'(s_busy), 0);
    chk("idle_grant", int'(s_grant), 0);
  endtask

  // Higher-level arbitration reference: first pending requester after the last served.
  function automatic int rr_pick(input logic [3:0] pend, input int last);
    for (int k = 1; k <= 4; k++)
      if (pend[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  typedef struct {
    logic [3:0] set;
    logic [3:0] d;
    int         exp_idx;
    bit         early;
  } vec_t;

  vec_t tbl[10];
  logic [3:0] dopts[5];

  initial begin
    int last;
    int pred;
    bit used8;
    logic [3:0] mask;
    logic [3:0] d;
    logic [7:0] fr;
    bit got;

    tbl[0] = '{4'b0001, 4'h2, 0, 1'b0};
    tbl[1] = '{4'b0100, 4'h0, 2, 1'b0};
    tbl[2] = '{4'b0101, 4'h1, 0, 1'b0};
    tbl[3] = '{4'b0000, 4'h0, 2, 1'b1};
    tbl[4] = '{4'b1000, 4'h0, 3, 1'b0};
    tbl[5] = '{4'b1111, 4'h0, 0, 1'b0};
    tbl[6] = '{4'b0000, 4'h0, 1, 1'b0};
    tbl[7] = '{4'b0000, 4'h0, 2, 1'b0};
    tbl[8] = '{4'b0000, 4'h0, 3, 1'b0};
    tbl[9] = '{4'b0001, 4'h0, 0, 1'b0};
    dopts  = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", int'(grant_m), 0);
    chk("rst_done", int'(done_m), 0);
    chk("rst_busy", int'(busy_m), 0);
    chk("rst_data", int'(td_m), 0);
    chk("rst_ctl", int'({to_m, ack_m, rst_m}), 0);
    chk("rst_wd", int'({grant_w, done_w, to_w, busy_w, td_w, ack_w, rst_w}), 0);
    reset = 1'b0;

    // Table of arbitration vectors on the main instance
    use_wd = 1'b0;
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 4; i++) if (tbl[v].set[i]) raise(i, tbl[v].d);
      run_job(tbl[v].exp_idx, (int'(cur_d(tbl[v].exp_idx)) + 1) * 1000 + 1, 1'b0, tbl[v].early);
    end
    last = 0;

    // Random request traffic, then drain whatever is still pending
    used8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j < 5) begin
        mask = 4'($urandom_range(0, 15));
        if (req_m == 0 && mask == 0) mask = 4'(1 << $urandom_range(0, 3));
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) begin
            d = dopts[$urandom_range(0, 4)];
            if (d == 4'h8) begin
              if (used8) d = 4'h3;
              used8 = 1'b1;
            end
            raise(i, d);
          end
        end
      end
      if (req_m == 0) break;
      pred = rr_pick(req_m, last);
      run_job(pred, (int'(cur_d(pred)) + 1) * 1000 + 1, 1'b0, 1'($urandom_range(0, 1)));
      last = pred;
    end

    // Reset while the sixth frame bit is on the line
    raise(0, 4'h5);
    fr  = {4'b1101, 4'h5};
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (grant_m != 0) begin got = 1'b1; break; end
    end
    if (!got) chk("rst_send_grant_wait", 0, 1);
    for (int b = 0; b < 6 && got; b++) begin
      if (b > 0) @(negedge clk);
      chk($sformatf("pre_rst_bit%0d", b), int'(td_m), int'(fr[7-b]));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_data", int'(td_m), 0);
    chk("midrst_grant", int'(grant_m), 0);
    chk("midrst_busy", int'(busy_m), 0);
    chk("midrst_done", int'(done_m), 0);
    reset = 1'b0;
    run_job(0, 6001, 1'b0, 1'b0);

    // Watchdog, lost frame and done-on-entry on the short-watchdog instance
    use_wd = 1'b1;
    tcnt_w = 1'b1; tdone_w = 1'b0;
    raise(0, 4'h3);
    run_job(0, 100, 1'b1, 1'b0);
    tcnt_w = 1'b0;
    raise(1, 4'h9);
    run_job(1, 2, 1'b1, 1'b0);
    tcnt_w = 1'b1; tdone_w = 1'b1;
    raise(2, 4'hC);
    run_job(2, 1, 1'b1, 1'b0);
    tdone_w = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
